// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB initiator.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_master.sv
// APB initiator: one single-word transfer at a time from a valid/ready command port.
// Optional pready wait states with timeout are enabled by defining APB_MASTER_PREADY_EN.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  n_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  apb_state_t state_r;
  logic       accept_s;
  logic       complete_s;
  logic       timeout_s;

`ifdef APB_MASTER_PREADY_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt_r;
  logic              rsp_err_r;

  // Timeout fires on the low-pready ACCESS cycle that brings the wait count to TIMEOUT.
  always_comb begin
    timeout_s = 1'b0;
    if ((state_r == ACCESS) && !pready && (wait_cnt_r == WAIT_W'(TIMEOUT - 1))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  assign complete_s = (state_r == ACCESS) && (pready || timeout_s);

  // Wait-state counter, restarted for every accepted command.
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (accept_s) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if ((state_r == ACCESS) && !pready && !timeout_s) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Error flag follows each completion; qualified externally by rsp_valid.
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_err_r <= 1'b0;
    end else if (complete_s) begin
      rsp_err_r <= timeout_s;
    end else begin
      rsp_err_r <= rsp_err_r;
    end
  end

  assign rsp_err = rsp_err_r;
`else
  logic unused_s;

  assign unused_s   = pready & (TIMEOUT > 0);
  assign timeout_s  = 1'b0;
  assign complete_s = (state_r == ACCESS);
  assign rsp_err    = 1'b0;
`endif

  assign cmd_ready = (state_r == IDLE) || complete_s;
  assign accept_s  = cmd_valid && cmd_ready;

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= {ADDR_WIDTH{1'b0}};
      pdata     <= {DATA_WIDTH{1'b0}};
      rsp_valid <= 1'b0;
      rsp_rdata <= {DATA_WIDTH{1'b0}};
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pdata   <= cmd_wdata;
          end else begin
            state_r <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
          end
        end
        SETUP: begin
          state_r <= ACCESS;
          psel    <= 1'b1;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (complete_s) begin
            rsp_valid <= 1'b1;
            // pwrite still names the finishing transfer here; a new accept updates it below.
            if (!pwrite && !timeout_s) begin
              rsp_rdata <= prdata;
            end else begin
              rsp_rdata <= rsp_rdata;
            end
            if (accept_s) begin
              state_r <= SETUP;
              psel    <= 1'b1;
              penable <= 1'b0;
              pwrite  <= cmd_write;
              paddr   <= cmd_addr;
              pdata   <= cmd_wdata;
            end else begin
              state_r <= IDLE;
              psel    <= 1'b0;
              penable <= 1'b0;
            end
          end else begin
            state_r <= ACCESS;
            psel    <= 1'b1;
            penable <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: transaction-level model plus directed and random traffic.
module tb_apb_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;
`ifdef APB_MASTER_PREADY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic          pclk = 1'b0;
  logic          n_rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b1;

  always #5 pclk = ~pclk;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pdata(pdata),
    .prdata(prdata), .pready(pready)
  );

  int nchecks = 0;
  int nerrs   = 0;

  // Model: one transfer in flight, described by how many cycles it has spent on the bus.
  bit          m_busy;
  int          m_phase;   // 0 = setup cycle, >=1 = access cycles
  int          m_low;     // access edges seen with pready low
  bit          m_w;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic [DW-1:0] m_rdata;
  bit          m_rv;
  bit          m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_phase = 0; m_low = 0; m_w = 0; m_a = '0; m_d = '0;
    m_rdata = '0; m_rv = 0; m_err = 0;
  endtask

  function automatic bit m_completing();
    return m_busy && (m_phase >= 1) && (!PEN || pready || (m_low + 1 == TMO));
  endfunction

  function automatic bit m_ready();
    return !m_busy || m_completing();
  endfunction

  task automatic model_edge();
    bit comp;
    bit rdy;
    comp = m_completing();
    rdy  = !m_busy || comp;
    m_rv = 0;
    if (comp) begin
      m_rv  = 1;
      m_err = PEN && !pready;
      if (!m_w && !m_err) m_rdata = prdata;
      m_busy = 0;
    end else if (m_busy) begin
      if (m_phase >= 1 && !pready) m_low++;
      m_phase++;
    end
    if (cmd_valid && rdy) begin
      m_busy = 1; m_phase = 0; m_low = 0;
      m_w = cmd_write; m_a = cmd_addr; m_d = cmd_wdata;
    end
  endtask

  task automatic check_outputs();
    chk("psel", psel, m_busy);
    chk("penable", penable, m_busy && (m_phase >= 1));
    chk("pwrite", pwrite, m_w);
    chk("paddr", paddr, m_a);
    chk("pdata", pdata, m_d);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    if (m_rv) chk("rsp_err", rsp_err, m_err);
  endtask

  // One clock: check the combinational ready, cross the edge, check registered outputs.
  task automatic step();
    #1;
    chk("cmd_ready", cmd_ready, m_ready());
    @(posedge pclk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_cmd(input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d;
  endtask

  initial begin
    int  cnt_psel;
    int  cnt_rsp;
    int  cnt_acc;
    bit  have;
    bit  acc;

    model_reset();
    n_rst = 1'b0;
    repeat (4) @(posedge pclk);
    #2 n_rst = 1'b1;
    #1;
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    @(posedge pclk); #1;

    // Directed write 0x2 <- 0x4
    pready = 1'b1;
    set_cmd(1'b1, 1'b1, 32'h2, 32'h4);
    step();
    chk("wr_setup_psel", psel, 1'b1);
    chk("wr_setup_penable", penable, 1'b0);
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("wr_acc_penable", penable, 1'b1);
    chk("wr_acc_paddr", paddr, 32'h2);
    chk("wr_acc_pdata", pdata, 32'h4);
    chk("wr_acc_pwrite", pwrite, 1'b1);
    step();
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_idle_psel", psel, 1'b0);

    // Directed read 0xC, slave returns 0x4
    prdata = 32'h4;
    set_cmd(1'b1, 1'b0, 32'hC, 32'h0);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("rd_pwrite", pwrite, 1'b0);
    step();
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h4);

    // Three back-to-back commands
    cnt_psel = 0; cnt_rsp = 0;
    for (int i = 0; i < 3; i++) begin
      prdata = 32'h100 + 32'(i);
      set_cmd(1'b1, i[0], 32'h10 + 32'(i), 32'h20 + 32'(i));
      step();
      cnt_psel += int'(psel); cnt_rsp += int'(rsp_valid);
      step();
      cnt_psel += int'(psel); cnt_rsp += int'(rsp_valid);
    end
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    cnt_psel += int'(psel); cnt_rsp += int'(rsp_valid);
    step();
    cnt_psel += int'(psel); cnt_rsp += int'(rsp_valid);
    chk("b2b_psel_cycles", 64'(cnt_psel), 64'd6);
    chk("b2b_rsp_pulses", 64'(cnt_rsp), 64'd3);

`ifdef APB_MASTER_PREADY_EN
    // pready low for three access edges: ACCESS lasts four cycles
    prdata = 32'hABCD;
    set_cmd(1'b1, 1'b0, 32'h30, 32'h0);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    pready = 1'b0;
    step();
    cnt_acc = int'(penable);
    for (int j = 0; j < 6; j++) begin
      pready = (j >= 3);
      step();
      cnt_acc += int'(penable);
    end
    chk("wait_access_cycles", 64'(cnt_acc), 64'd4);
    chk("wait_rdata", rsp_rdata, 32'hABCD);

    // pready stuck low: timeout after TMO access cycles
    prdata = 32'h5555;
    set_cmd(1'b1, 1'b0, 32'h34, 32'h0);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    pready = 1'b0;
    step();
    cnt_acc = int'(penable);
    cnt_rsp = 0;
    for (int j = 0; j < 10 && cnt_rsp == 0; j++) begin
      step();
      cnt_acc += int'(penable);
      if (rsp_valid) begin
        cnt_rsp = 1;
        chk("tmo_rsp_err", rsp_err, 1'b1);
        chk("tmo_rdata_kept", rsp_rdata, 32'hABCD);
      end
    end
    chk("tmo_completed", 64'(cnt_rsp), 64'd1);
    chk("tmo_access_cycles", 64'(cnt_acc), 64'(TMO));
    pready = 1'b1;
`else
    cnt_acc = 0;
`endif

    // Reset in the middle of ACCESS
    set_cmd(1'b1, 1'b1, 32'h44, 32'h99);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("rst_mid_in_access", penable, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    chk("rst_mid_psel", psel, 1'b0);
    chk("rst_mid_penable", penable, 1'b0);
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mid_paddr", paddr, 32'h0);
    model_reset();
    repeat (2) @(posedge pclk);
    #2 n_rst = 1'b1;
    step();
    set_cmd(1'b1, 1'b1, 32'h48, 32'h77);
    step();
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    chk("post_rst_rsp_valid", rsp_valid, 1'b1);

    // Randomised traffic against the model
    have = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!have && ($urandom_range(0, 3) != 0)) begin
        set_cmd(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        have = 1;
      end else if (!have) begin
        cmd_valid = 1'b0;
      end
      prdata = $urandom;
      pready = ($urandom_range(0, 3) != 0);
      #1;
      acc = cmd_valid && m_ready();
      step();
      if (acc) begin
        have = 0;
        cmd_valid = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule
